// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package rf_wb_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  // One pending register-file write.
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// In-order circular buffer of wb_entry_t with wrap-around pointers.
// With RF_WB_BYPASS_EN defined, also exposes all slots in age order
// (index 0 = head) so the top level can search them for forwarding.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
`ifdef RF_WB_BYPASS_EN
  ,
  output wb_entry_t [DEPTH-1:0]  entries
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  wb_entry_t     mem_q [DEPTH];

  // Next-state for pointers and occupancy; DEPTH is a power of 2 so pointers wrap for free.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, else a latch is inferred.
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; slots are only read when the occupancy count marks them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef RF_WB_BYPASS_EN
  // Age-ordered view of all slots for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem_q[rd_ptr_q + PW'(i)];
    end
  end
`endif

endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the 32x32 register file: in-order FIFO,
// one-entry registered output stage driving AddrD/DataD/RegWEn, and a
// per-register pending-write scoreboard for RAW hazard detection.
// Optional macro RF_WB_BYPASS_EN adds forwarding outputs (fwd_hit_*/fwd_data_*).
// Address and data widths come from rf_wb_pkg.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_addr,
  input  logic [XLEN-1:0]        in_data,
  input  logic                   hold,
  input  logic [AW-1:0]          q_addr_a,
  input  logic [AW-1:0]          q_addr_b,
  output logic                   busy_a,
  output logic                   busy_b,
  output logic [$clog2(DEPTH):0] count,
`ifdef RF_WB_BYPASS_EN
  output logic                   fwd_hit_a,
  output logic                   fwd_hit_b,
  output logic [XLEN-1:0]        fwd_data_a,
  output logic [XLEN-1:0]        fwd_data_b,
`endif
  output logic [AW-1:0]          AddrD,
  output logic [XLEN-1:0]        DataD,
  output logic                   RegWEn
);

  // Up to DEPTH queued plus one in the output stage may be outstanding per register.
  localparam int SBW = $clog2(DEPTH + 2);
  localparam int CW  = $clog2(DEPTH) + 1;

  logic            push, pop, fifo_full, fifo_empty;
  wb_entry_t       fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            regwen_q, regwen_d;
  logic [AW-1:0]   addr_q,   addr_d;
  logic [XLEN-1:0] data_q,   data_d;
  logic [SBW-1:0]  sb_q [NUM_REGS];
  logic [SBW-1:0]  sb_d [NUM_REGS];

  // Writes to x0 complete the handshake but are discarded.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = !fifo_empty && !hold;

`ifdef RF_WB_BYPASS_EN
  wb_entry_t [DEPTH-1:0] fifo_entries;
`endif

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{addr: in_addr, data: in_data}),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
`ifdef RF_WB_BYPASS_EN
    .entries    (fifo_entries),
`endif
    .count      (fifo_count)
  );

  // Output stage: a popped entry is presented for exactly one cycle; address/data hold otherwise.
  always_comb begin
    regwen_d = pop;
    addr_d   = pop ? fifo_head.addr : addr_q;
    data_d   = pop ? fifo_head.data : data_q;
  end

  // Scoreboard: count up on accepted write, down as the entry leaves the output stage.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = sb_q[r];
      if (push && in_addr == AW'(r))   sb_d[r] = sb_d[r] + SBW'(1);
      if (regwen_q && addr_q == AW'(r)) sb_d[r] = sb_d[r] - SBW'(1);
    end
  end

  // Output stage and scoreboard registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwen_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= '0;
    end else begin
      regwen_q <= regwen_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= sb_d[r];
    end
  end

  assign busy_a = (q_addr_a != '0) && (sb_q[q_addr_a] != '0);
  assign busy_b = (q_addr_b != '0) && (sb_q[q_addr_b] != '0);
  assign count  = fifo_count;
  assign AddrD  = addr_q;
  assign DataD  = data_q;
  assign RegWEn = regwen_q;

`ifdef RF_WB_BYPASS_EN
  // Youngest match wins: output stage is oldest, then FIFO from head to tail. Returns {hit, data}.
  function automatic logic [XLEN:0] fwd_lookup(
    input logic [AW-1:0]         q,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [CW-1:0]         n,
    input logic                  out_vld,
    input logic [AW-1:0]         out_addr,
    input logic [XLEN-1:0]       out_data
  );
    logic [XLEN:0] res;
    res = '0;
    if (q != '0) begin
      if (out_vld && out_addr == q) res = {1'b1, out_data};
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < n && ents[i].addr == q) res = {1'b1, ents[i].data};
      end
    end
    return res;
  endfunction

  // Forwarding search for both decode source operands.
  always_comb begin
    {fwd_hit_a, fwd_data_a} = fwd_lookup(q_addr_a, fifo_entries, fifo_count, regwen_q, addr_q, data_q);
    {fwd_hit_b, fwd_data_b} = fwd_lookup(q_addr_b, fifo_entries, fifo_count, regwen_q, addr_q, data_q);
  end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed self-checking bench for rf_writeback_queue (DEPTH=4).
// Outputs are sampled 2 ns after each rising edge; inputs change at the same point.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, hold;
  logic        in_ready;
  logic [4:0]  in_addr, q_addr_a, q_addr_b;
  logic [31:0] in_data;
  logic        busy_a, busy_b;
  logic [2:0]  count;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic        RegWEn;
`ifdef RF_WB_BYPASS_EN
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .hold     (hold),
    .q_addr_a (q_addr_a),
    .q_addr_b (q_addr_b),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .count    (count),
`ifdef RF_WB_BYPASS_EN
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
`endif
    .AddrD    (AddrD),
    .DataD    (DataD),
    .RegWEn   (RegWEn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_pulse(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_wen"},  RegWEn, 1'b1);
    check({tag, "_addr"}, AddrD,  a);
    check({tag, "_data"}, DataD,  d);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    in_addr = '0; in_data = '0; q_addr_a = 5'd5; q_addr_b = 5'd0;
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    check("rst_ready",  in_ready, 1'b1);
    check("rst_count",  count,    3'd0);
    check("rst_wen",    RegWEn,   1'b0);
    check("rst_addr",   AddrD,    5'd0);
    check("rst_data",   DataD,    32'd0);
    check("rst_busy_a", busy_a,   1'b0);

    // 1: single write x5
    push(5'd5, 32'hDEADBEEF);
    check("t1_busy_c1",  busy_a, 1'b1);
    check("t1_wen_c1",   RegWEn, 1'b0);
    check("t1_count_c1", count,  3'd1);
    tick();
    check_pulse("t1_pulse", 5'd5, 32'hDEADBEEF);
    check("t1_busy_c2",  busy_a, 1'b1);
    check("t1_count_c2", count,  3'd0);
    tick();
    check("t1_wen_c3",   RegWEn, 1'b0);
    check("t1_busy_c3",  busy_a, 1'b0);
    check("t1_addr_hold", AddrD, 5'd5);

    // 2: fill while held, then drain in order
    hold = 1'b1; q_addr_b = 5'd3;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 'h11));
    check("t2_ready_full", in_ready, 1'b0);
    check("t2_count_full", count,    3'd4);
    check("t2_busy_x3",    busy_b,   1'b1);
    check("t2_wen_held",   RegWEn,   1'b0);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_pulse($sformatf("t2_drain%0d", i), 5'(i), 32'(i * 'h11));
      check($sformatf("t2_count%0d", i), count, 3'(4 - i));
    end
    tick();
    check("t2_wen_end",   RegWEn, 1'b0);
    check("t2_busy_end",  busy_b, 1'b0);

    // 3: write to x0 is accepted and dropped
    q_addr_a = 5'd0;
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
    #1 check("t3_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t3_count",  count,  3'd0);
    check("t3_busy0",  busy_a, 1'b0);
    tick();
    check("t3_wen",    RegWEn, 1'b0);

    // 4: two writes to x7; busy until the second leaves the output stage
    hold = 1'b1; q_addr_a = 5'd7;
    push(5'd7, 32'd1);
    push(5'd7, 32'd2);
    check("t4_busy_held", busy_a, 1'b1);
`ifdef RF_WB_BYPASS_EN
    check("t4_fwd_hit",  fwd_hit_a,  1'b1);
    check("t4_fwd_data", fwd_data_a, 32'd2);
`endif
    hold = 1'b0;
    tick();
    check_pulse("t4_p1", 5'd7, 32'd1);
    check("t4_busy_p1", busy_a, 1'b1);
    tick();
    check_pulse("t4_p2", 5'd7, 32'd2);
    check("t4_busy_p2", busy_a, 1'b1);
`ifdef RF_WB_BYPASS_EN
    check("t4_fwd_out", fwd_data_a, 32'd2);
`endif
    tick();
    check("t4_busy_clr", busy_a, 1'b0);
    check("t4_wen_end",  RegWEn, 1'b0);

    // 5: full queue, drain running, producer waiting
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(8 + i), 32'h80 + 32'(i));
    hold = 1'b0;
    in_valid = 1'b1; in_addr = 5'd12; in_data = 32'hC0;
    #1 check("t5_ready_full", in_ready, 1'b0);
    tick();
    check_pulse("t5_pop8", 5'd8, 32'h80);
    check("t5_count_a", count,    3'd3);
    check("t5_ready_a", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_pulse("t5_pop9", 5'd9, 32'h81);
    check("t5_count_b", count, 3'd3);
    tick(); check_pulse("t5_pop10", 5'd10, 32'h82);
    tick(); check_pulse("t5_pop11", 5'd11, 32'h83);
    tick(); check_pulse("t5_pop12", 5'd12, 32'hC0);
    check("t5_count_end", count, 3'd0);
    tick();
    check("t5_wen_end", RegWEn, 1'b0);

    // 6: reset mid-drain discards queued and in-flight writes
    hold = 1'b1; q_addr_a = 5'd14; q_addr_b = 5'd15;
    push(5'd13, 32'hD);
    push(5'd14, 32'hE);
    push(5'd15, 32'hF);
    hold = 1'b0;
    tick();
    check_pulse("t6_pop13", 5'd13, 32'hD);
    rst_n = 1'b0;
    #1;
    check("t6_wen_async",   RegWEn, 1'b0);
    check("t6_count_async", count,  3'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_count",  count,  3'd0);
    check("t6_busy_a", busy_a, 1'b0);
    check("t6_busy_b", busy_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_no_wen%0d", i), RegWEn, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
